// File: rtl/proc_pkg.sv
// Shared processor definitions: sequencer states and opcode encodings
// also used by the RAM and ALU execute stages.
package proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_FETCH_OP  = 3'd1,
    S_FETCH_ARG = 3'd2,
    S_CAPTURE   = 3'd3,
    S_EXEC      = 3'd4,
    S_MEM_WAIT  = 3'd5,
    S_HALT      = 3'd6
  } seq_state_e;

  localparam logic [15:0] OPC_HALT    = 16'hFFFF;
  localparam logic [15:0] OPC_NOP     = 16'h0000;
  localparam logic [3:0]  OPC_RAM_NIB = 4'h4;
  localparam logic [3:0]  OPC_RAM_RD  = 4'h2;

  function automatic logic is_ram_read(input logic [15:0] op);
    return (op[15:12] == OPC_RAM_NIB) && (op[11:8] == OPC_RAM_RD);
  endfunction

endpackage

// File: rtl/instr_sequencer_pc_counter.sv
// Program counter: advances by one instruction (two words) or loads a
// branch target, only when the sequencer signals the execute cycle.
module pc_counter #(
  parameter int PC_WIDTH = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                advance,
  input  logic                jump_en,
  input  logic [PC_WIDTH-1:0] jump_addr,
  output logic [PC_WIDTH-1:0] pc,
  output logic [PC_WIDTH-1:0] pc_plus1
);

  logic [PC_WIDTH-1:0] pc_q, pc_d;

  always_comb begin
    pc_d = pc_q;
    if (advance) pc_d = jump_en ? jump_addr : pc_q + PC_WIDTH'(2);
  end

  always_ff @(posedge clk) begin
    if (!reset) pc_q <= '0;
    else        pc_q <= pc_d;
  end

  assign pc       = pc_q;
  assign pc_plus1 = pc_q + PC_WIDTH'(1);

endmodule

// File: rtl/instr_sequencer.sv
// Two-word instruction fetch/issue sequencer: fetches opcode and operand,
// broadcasts them for one execute cycle (two for RAM reads), and halts on 16'hFFFF.
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int PC_WIDTH   = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  run,
  output logic [PC_WIDTH-1:0]   prog_addr,
  output logic                  prog_rd_en,
  input  logic [DATA_WIDTH-1:0] prog_data,
  input  logic                  jump_en,
  input  logic [PC_WIDTH-1:0]   jump_addr,
  output logic [DATA_WIDTH-1:0] opcode,
  output logic [DATA_WIDTH-1:0] operand,
  output logic                  read_enable,
  output logic                  issue,
  output logic                  halted,
  output logic [PC_WIDTH-1:0]   pc
);

  seq_state_e            state_q, state_d;
  logic [DATA_WIDTH-1:0] op_q, op_d;
  logic [DATA_WIDTH-1:0] arg_q, arg_d;
  logic [PC_WIDTH-1:0]   pc_plus1;
  logic                  pc_advance;

  pc_counter #(.PC_WIDTH(PC_WIDTH)) u_pc (
    .clk      (clk),
    .reset    (reset),
    .advance  (pc_advance),
    .jump_en  (jump_en),
    .jump_addr(jump_addr),
    .pc       (pc),
    .pc_plus1 (pc_plus1)
  );

  always_comb begin
    state_d     = state_q;
    op_d        = op_q;
    arg_d       = arg_q;
    prog_addr   = '0;
    prog_rd_en  = 1'b0;
    opcode      = DATA_WIDTH'(OPC_NOP);
    operand     = DATA_WIDTH'(OPC_NOP);
    read_enable = 1'b0;
    issue       = 1'b0;
    halted      = 1'b0;
    pc_advance  = 1'b0;
    case (state_q)
      S_IDLE: if (run) state_d = S_FETCH_OP;
      S_FETCH_OP: begin
        prog_addr  = pc;
        prog_rd_en = 1'b1;
        state_d    = S_FETCH_ARG;
      end
      S_FETCH_ARG: begin
        op_d       = prog_data;
        prog_addr  = pc_plus1;
        prog_rd_en = 1'b1;
        state_d    = S_CAPTURE;
      end
      S_CAPTURE: begin
        arg_d   = prog_data;
        state_d = (op_q == DATA_WIDTH'(OPC_HALT)) ? S_HALT : S_EXEC;
      end
      S_EXEC: begin
        opcode      = op_q;
        operand     = arg_q;
        issue       = 1'b1;
        pc_advance  = 1'b1;
        read_enable = is_ram_read(op_q[15:0]);
        state_d     = read_enable ? S_MEM_WAIT : S_FETCH_OP;
      end
      // Only RAM reads get here, so read_enable simply stays high.
      S_MEM_WAIT: begin
        opcode      = op_q;
        operand     = arg_q;
        read_enable = 1'b1;
        state_d     = S_FETCH_OP;
      end
      S_HALT:  halted  = 1'b1;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      arg_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      arg_q   <= arg_d;
    end
  end

endmodule
